// File: rtl/param_memory_pkg.sv
// Shared types and helpers for the parameterised single-port memory and its clear engine.
package param_memory_pkg;

  typedef enum logic {
    MEM_INIT = 1'b0,
    MEM_RUN  = 1'b1
  } mem_state_e;

  localparam int BYTE_W = 8;

  function automatic int bytes_per_word(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/param_memory_clear_ctr.sv
// Clear-engine address counter: restarts at 0 on i_start and walks 0..DEPTH-1 while enabled.
module mem_clear_ctr #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_start,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_cnt;

  // Holds at LAST so the final clear address stays stable until the FSM leaves INIT
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = i_en && (r_cnt == LAST);

endmodule

// File: rtl/param_memory.sv
// Single-port synchronous RAM with valid/ready requests, byte enables, a 1-cycle registered
// read response, out-of-range flagging and a post-reset clear engine.
module param_memory
  import param_memory_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int              BPW     = bytes_per_word(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  mem_state_e        r_state;
  logic              r_init_busy;
  logic              r_req_ready;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_rsp_vld_p1;
  logic              r_rsp_err_p1;
  logic [DATA_W-1:0] r_rsp_data_p1;

  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_clr_done;
  logic              w_clr_en;
  logic              w_acc;
  logic              w_in_range;

  assign w_clr_en   = (r_state == MEM_INIT);
  assign w_acc      = req_valid && r_req_ready;
  // One extra bit so DEPTH == 2**ADDR_W compares correctly with no wrap
  assign w_in_range = ({1'b0, req_addr} < DEPTH_X);

  mem_clear_ctr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_ctr (
    .clk     (clk),
    .i_start (reset),
    .i_en    (w_clr_en),
    .o_cnt   (w_clr_addr),
    .o_done  (w_clr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= MEM_INIT;
      r_init_busy <= 1'b1;
      r_req_ready <= 1'b0;
    end else begin
      case (r_state)
        MEM_INIT: begin
          if (w_clr_done) begin
            r_state     <= MEM_RUN;
            r_init_busy <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        MEM_RUN: begin
          r_state <= MEM_RUN;
        end
        default: begin
          r_state     <= MEM_INIT;
          r_init_busy <= 1'b1;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the clear engine overwrites every word after each reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == MEM_INIT) begin
        r_mem[w_clr_addr] <= INIT_VAL;
      end else if (w_acc && req_write && w_in_range) begin
        for (int i = 0; i < BPW; i++) begin
          if (req_be[i]) begin
            r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // p1: registered read response, one cycle after accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_vld_p1  <= 1'b0;
      r_rsp_err_p1  <= 1'b0;
      r_rsp_data_p1 <= '0;
    end else begin
      r_rsp_vld_p1 <= w_acc && !req_write;
      r_rsp_err_p1 <= w_acc && !w_in_range;
      if (w_acc && !req_write) begin
        r_rsp_data_p1 <= w_in_range ? r_mem[req_addr] : '0;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign init_busy = r_init_busy;
  assign rsp_valid = r_rsp_vld_p1;
  assign rsp_err   = r_rsp_err_p1;
  assign rsp_data  = r_rsp_data_p1;

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench for param_memory in a 48 x 32-bit configuration with a non-zero clear value.
module tb_param_memory;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 6;
  localparam int          DEPTH  = 48;
  localparam logic [31:0] IVAL   = 32'hA5A5_A5A5;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [3:0]        req_be = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              init_busy;

  int          n_chk = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  rsp_t        sb_q[$];
  rsp_t        mon_e;
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd = '0;
  int          n;

  param_memory #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_VAL (IVAL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (rsp_valid === 1'b1 || rsp_err === 1'b1)) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_rsp", {30'd0, rsp_valid, rsp_err, rsp_data}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("rsp", {30'd0, rsp_valid, rsp_err, rsp_data}, {30'd0, mon_e});
      end
    end
  end

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) model[i] = IVAL;
    last_rd = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    reset_model();
  endtask

  task automatic wait_init(output int cnt);
    cnt = 0;
    while (init_busy !== 1'b0 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  // One request cycle; called at posedge+1, returns at the next posedge+1
  task automatic req(input logic wr, input logic [5:0] a, input logic [31:0] wd, input logic [3:0] be);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    if (req_ready === 1'b1) begin
      if (wr) begin
        if (a < DEPTH) begin
          for (int i = 0; i < 4; i++) if (be[i]) model[a][8*i +: 8] = wd[8*i +: 8];
        end else begin
          sb_q.push_back('{vld: 1'b0, err: 1'b1, data: last_rd});
        end
      end else begin
        if (a < DEPTH) begin
          last_rd = model[a];
          sb_q.push_back('{vld: 1'b1, err: 1'b0, data: model[a]});
        end else begin
          last_rd = '0;
          sb_q.push_back('{vld: 1'b1, err: 1'b1, data: 32'd0});
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    mon_en = 1'b1;

    check_eq("rst_busy",  {63'd0, init_busy}, 64'd1);
    check_eq("rst_ready", {63'd0, req_ready}, 64'd0);
    check_eq("rst_vld",   {63'd0, rsp_valid}, 64'd0);
    check_eq("rst_err",   {63'd0, rsp_err},   64'd0);
    check_eq("rst_data",  {32'd0, rsp_data},  64'd0);
    wait_init(n);
    check_eq("init_len", 64'(n), 64'd48);

    // Clear sweep readback, back-to-back
    req(1'b0, 6'd0,  '0, '0);
    req(1'b0, 6'd23, '0, '0);
    req(1'b0, 6'd47, '0, '0);

    // Write then read next cycle
    req(1'b1, 6'd1, 32'h02, 4'hF);
    req(1'b0, 6'd1, '0, '0);
    req(1'b1, 6'd2, 32'h03, 4'hF);
    req(1'b0, 6'd2, '0, '0);
    req(1'b0, 6'd1, '0, '0);

    // Byte enables and the all-zero enable case
    req(1'b1, 6'd5, 32'h1122_3344, 4'hF);
    req(1'b1, 6'd5, 32'hAABB_CCDD, 4'b0101);
    req(1'b0, 6'd5, '0, '0);
    req(1'b1, 6'd5, 32'hDEAD_BEEF, 4'b0000);
    req(1'b0, 6'd5, '0, '0);

    // Out of range around the DEPTH boundary
    req(1'b0, 6'd50, '0, '0);
    req(1'b0, 6'd2,  '0, '0);
    req(1'b1, 6'd50, 32'h7777_7777, 4'hF);
    req(1'b1, 6'd48, 32'h6666_6666, 4'hF);
    req(1'b0, 6'd63, '0, '0);
    req(1'b0, 6'd48, '0, '0);
    req(1'b0, 6'd47, '0, '0);
    req(1'b0, 6'd18, '0, '0);
    req(1'b0, 6'd2,  '0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the accept cycle of a read cancels the response
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd2; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    reset_model();
    check_eq("cancel_vld",   {63'd0, rsp_valid}, 64'd0);
    check_eq("cancel_data",  {32'd0, rsp_data},  64'd0);
    check_eq("cancel_busy",  {63'd0, init_busy}, 64'd1);
    check_eq("cancel_ready", {63'd0, req_ready}, 64'd0);
    wait_init(n);
    check_eq("init_len_run_rst", 64'(n), 64'd48);
    req(1'b0, 6'd1, '0, '0);
    req(1'b0, 6'd5, '0, '0);

    // Reset at clear cycle 20 restarts the sweep
    do_reset();
    repeat (20) begin
      @(posedge clk); #1;
    end
    do_reset();
    wait_init(n);
    check_eq("init_len_mid_rst", 64'(n), 64'd48);

    // Request held through INIT is first accepted in the first RUN cycle
    do_reset();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd3; req_wdata = 32'hFF; req_be = 4'hF;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("init_hold_delay", 64'(n), 64'd48);
    req(1'b1, 6'd3, 32'hFF, 4'hF);
    req(1'b0, 6'd3, '0, '0);
    req(1'b0, 6'd4, '0, '0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
